// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and shared memory port seen by
// mem_port_arbiter. The arbiter uses the slave view; requesters and the
// memory model use the master view.
interface mem_port_arbiter_if;
  // fetch port
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  // data port
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ready;
  logic [31:0] dm_rdata;
  logic        addr_err;
  // memory port
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    output if_ready, if_rdata, dm_ready, dm_rdata, addr_err,
           mem_valid, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    input  if_ready, if_rdata, dm_ready, dm_rdata, addr_err,
           mem_valid, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by an instruction-fetch port and a
// data port. One access is outstanding at a time. The data port normally
// wins, but after STARVE_MAX consecutive data grants with fetch waiting,
// fetch is forced through. Misaligned requests skip memory and complete
// with addr_err.
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_IF = 2'd1,
    GRANT_DM = 2'd2,
    RESP     = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [SW-1:0] streak_reg;
  logic [31:0] addr_reg;
  logic        we_reg;
  logic [31:0] wdata_reg;
  logic        owner_dm_reg;
  logic        err_reg;
  logic [31:0] if_rdata_reg;
  logic [31:0] dm_rdata_reg;

  logic        if_starved;
  logic        pick_dm;
  logic        pick_if;
  logic        grant;
  logic [31:0] sel_addr;
  logic        misalign;

  // Arbitration, only meaningful while IDLE: fetch wins when starved.
  assign if_starved = bus.if_req && (streak_reg == STREAK_MAX);
  assign pick_dm    = bus.dm_req && !if_starved;
  assign pick_if    = bus.if_req && !pick_dm;
  assign grant      = (state_reg == IDLE) && (pick_dm || pick_if);
  assign sel_addr   = pick_dm ? bus.dm_addr : bus.if_addr;
  assign misalign   = |sel_addr[1:0];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic; misaligned grants jump straight to the response.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (pick_dm || pick_if) begin
          if (misalign)     state_next = RESP;
          else if (pick_dm) state_next = GRANT_DM;
          else              state_next = GRANT_IF;
        end
      end
      GRANT_IF, GRANT_DM: begin
        if (bus.mem_ack) state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Consecutive data-grant counter while fetch is waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_reg <= '0;
    end else if (grant) begin
      if (pick_dm && bus.if_req && streak_reg != STREAK_MAX)
        streak_reg <= streak_reg + 1'b1;
      else if (!(pick_dm && bus.if_req))
        streak_reg <= '0;
    end
  end

  // Latch the winning request so the memory sees a stable payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg     <= '0;
      we_reg       <= 1'b0;
      wdata_reg    <= '0;
      owner_dm_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else if (grant) begin
      addr_reg     <= sel_addr;
      we_reg       <= pick_dm && bus.dm_we;
      wdata_reg    <= pick_dm ? bus.dm_wdata : 32'd0;
      owner_dm_reg <= pick_dm;
      err_reg      <= misalign;
    end
  end

  // Read-data capture; misaligned requests return zero, stores keep dm_rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rdata_reg <= '0;
      dm_rdata_reg <= '0;
    end else begin
      if (grant && misalign) begin
        if (pick_dm) dm_rdata_reg <= '0;
        else         if_rdata_reg <= '0;
      end
      if (state_reg == GRANT_IF && bus.mem_ack)
        if_rdata_reg <= bus.mem_rdata;
      if (state_reg == GRANT_DM && bus.mem_ack && !we_reg)
        dm_rdata_reg <= bus.mem_rdata;
    end
  end

  // Outputs; memory payload is forced to zero whenever no access is live.
  always_comb begin
    bus.mem_valid = (state_reg == GRANT_IF) || (state_reg == GRANT_DM);
    bus.mem_addr  = bus.mem_valid ? addr_reg : 32'd0;
    bus.mem_we    = (state_reg == GRANT_DM) && we_reg;
    bus.mem_wdata = (state_reg == GRANT_DM) ? wdata_reg : 32'd0;
    bus.if_ready  = (state_reg == RESP) && !owner_dm_reg;
    bus.dm_ready  = (state_reg == RESP) && owner_dm_reg;
    bus.addr_err  = (state_reg == RESP) && err_reg;
    bus.if_rdata  = if_rdata_reg;
    bus.dm_rdata  = dm_rdata_reg;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, simultaneous requests,
// starvation limit, delayed store, misaligned access and mid-access reset.
module tb_mem_port_arbiter;

  logic clk;
  logic rst_n;
  int   tests;
  int   failures;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.STARVE_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    tests    = 0;
    failures = 0;
    rst_n    = 1'b1;
    bus.if_req = 0; bus.if_addr = 0;
    bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = 0; bus.dm_wdata = 0;
    bus.mem_rdata = 0; bus.mem_ack = 0;
    #1 rst_n = 1'b0;
    #1;
    // reset state
    check("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
    check("rst_mem_addr",  bus.mem_addr, 32'd0);
    check("rst_ready",     32'({bus.if_ready, bus.dm_ready, bus.addr_err}), 32'd0);
    check("rst_if_rdata",  bus.if_rdata, 32'd0);
    check("rst_dm_rdata",  bus.dm_rdata, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("idle_mem_valid", 32'(bus.mem_valid), 32'd0);

    // fetch only
    bus.if_req = 1; bus.if_addr = 32'h100;
    tick();
    check("if_mem_valid", 32'(bus.mem_valid), 32'd1);
    check("if_mem_addr",  bus.mem_addr, 32'h100);
    check("if_mem_we",    32'(bus.mem_we), 32'd0);
    check("if_ready_early", 32'(bus.if_ready), 32'd0);
    bus.mem_ack = 1; bus.mem_rdata = 32'h2008_0005;
    tick();
    bus.mem_ack = 0;
    $display("[TB] fetch 0x100 -> if_ready=%0d if_rdata=%h", bus.if_ready, bus.if_rdata);
    check("if_ready",     32'(bus.if_ready), 32'd1);
    check("if_rdata",     bus.if_rdata, 32'h2008_0005);
    check("if_resp_mv",   32'(bus.mem_valid), 32'd0);
    check("if_dm_ready",  32'(bus.dm_ready), 32'd0);
    bus.if_req = 0;
    tick();
    check("if_ready_pulse", 32'(bus.if_ready), 32'd0);

    // mem_ack while idle is ignored
    bus.mem_ack = 1;
    tick();
    bus.mem_ack = 0;
    check("idle_ack_mv",    32'(bus.mem_valid), 32'd0);
    check("idle_ack_ready", 32'({bus.if_ready, bus.dm_ready}), 32'd0);

    // simultaneous: DM first, then IF after an idle cycle
    bus.if_req = 1; bus.if_addr = 32'h104;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h200;
    tick();
    check("sim_dm_addr", bus.mem_addr, 32'h200);
    check("sim_dm_we",   32'(bus.mem_we), 32'd0);
    bus.mem_ack = 1; bus.mem_rdata = 32'h1111_2222;
    tick();
    bus.mem_ack = 0;
    $display("[TB] simultaneous dm 0x200 -> dm_ready=%0d dm_rdata=%h", bus.dm_ready, bus.dm_rdata);
    check("sim_dm_ready", 32'(bus.dm_ready), 32'd1);
    check("sim_if_ready", 32'(bus.if_ready), 32'd0);
    check("sim_dm_rdata", bus.dm_rdata, 32'h1111_2222);
    bus.dm_req = 0;
    tick();
    check("sim_gap_mv", 32'(bus.mem_valid), 32'd0);
    tick();
    check("sim_if_valid", 32'(bus.mem_valid), 32'd1);
    check("sim_if_addr",  bus.mem_addr, 32'h104);
    bus.mem_ack = 1; bus.mem_rdata = 32'h3333_4444;
    tick();
    bus.mem_ack = 0;
    $display("[TB] simultaneous if 0x104 -> if_ready=%0d if_rdata=%h", bus.if_ready, bus.if_rdata);
    check("sim_if_ready", 32'(bus.if_ready), 32'd1);
    check("sim_if_rdata", bus.if_rdata, 32'h3333_4444);
    bus.if_req = 0;
    tick();

    // starvation: grants 0..3 DM, 4 IF, 5 DM again
    bus.if_req = 1; bus.if_addr = 32'h300;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h400;
    for (int g = 0; g < 6; g++) begin
      tick();
      check("starve_addr", bus.mem_addr, (g == 4) ? 32'h300 : 32'h400);
      bus.mem_ack = 1; bus.mem_rdata = 32'hA000_0000 + 32'(g);
      tick();
      bus.mem_ack = 0;
      $display("[TB] starve grant %0d -> if_ready=%0d dm_ready=%0d", g, bus.if_ready, bus.dm_ready);
      check("starve_dm_ready", 32'(bus.dm_ready), (g == 4) ? 32'd0 : 32'd1);
      check("starve_if_ready", 32'(bus.if_ready), (g == 4) ? 32'd1 : 32'd0);
      tick();
    end
    bus.if_req = 0; bus.dm_req = 0;
    check("starve_if_rdata", bus.if_rdata, 32'hA000_0004);
    check("starve_dm_rdata", bus.dm_rdata, 32'hA000_0005);

    // store with 3-cycle ack delay
    bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h40; bus.dm_wdata = 32'hDEAD_BEEF;
    tick();
    for (int c = 0; c < 3; c++) begin
      check("st_valid", 32'(bus.mem_valid), 32'd1);
      check("st_we",    32'(bus.mem_we), 32'd1);
      check("st_addr",  bus.mem_addr, 32'h40);
      check("st_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
      check("st_ready_early", 32'(bus.dm_ready), 32'd0);
      bus.dm_addr = 32'h44; bus.dm_wdata = 32'h0;   // payload changes ignored
      if (c == 2) begin
        bus.mem_ack = 1; bus.mem_rdata = 32'hFFFF_FFFF;
      end
      tick();
    end
    bus.mem_ack = 0;
    $display("[TB] store 0x40 -> dm_ready=%0d dm_rdata=%h", bus.dm_ready, bus.dm_rdata);
    check("st_ready",  32'(bus.dm_ready), 32'd1);
    check("st_rdata",  bus.dm_rdata, 32'hA000_0005);
    bus.dm_req = 0; bus.dm_we = 0;
    tick();

    // misaligned load
    bus.dm_req = 1; bus.dm_addr = 32'h42;
    tick();
    $display("[TB] misaligned 0x42 -> dm_ready=%0d addr_err=%0d", bus.dm_ready, bus.addr_err);
    check("mis_valid",  32'(bus.mem_valid), 32'd0);
    check("mis_ready",  32'(bus.dm_ready), 32'd1);
    check("mis_err",    32'(bus.addr_err), 32'd1);
    check("mis_rdata",  bus.dm_rdata, 32'd0);
    bus.dm_req = 0;
    tick();
    check("mis_err_pulse", 32'(bus.addr_err), 32'd0);

    // reset during GRANT_DM
    bus.dm_req = 1; bus.dm_addr = 32'h80;
    tick();
    check("rr_valid", 32'(bus.mem_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    $display("[TB] reset mid-access -> mem_valid=%0d mem_addr=%h", bus.mem_valid, bus.mem_addr);
    check("rr_async_mv",   32'(bus.mem_valid), 32'd0);
    check("rr_async_addr", bus.mem_addr, 32'd0);
    check("rr_async_ifrd", bus.if_rdata, 32'd0);
    tick();
    rst_n = 1'b1;
    bus.dm_req = 0;
    bus.mem_ack = 1; bus.mem_rdata = 32'h5555_5555;
    tick();
    bus.mem_ack = 0;
    check("rr_late_ack_ready", 32'(bus.dm_ready), 32'd0);
    check("rr_late_ack_mv",    32'(bus.mem_valid), 32'd0);
    tick();
    check("rr_no_ready", 32'(bus.dm_ready), 32'd0);
    check("rr_dm_rdata", bus.dm_rdata, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: max consecutive data-port grants while fetch waits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 if_req  input  1  fetch request; held with if_addr until if_ready.
REQ-005 if_addr  input  32  fetch byte address.
REQ-006 if_ready  output  1  one-cycle pulse: fetch complete, if_rdata valid.
REQ-007 if_rdata  output  32  fetched word, registered.
REQ-008 dm_req  input  1  data request (MemRead or MemWrite); held with payload until dm_ready.
REQ-009 dm_we  input  1  1 = store, 0 = load.
REQ-010 dm_addr  input  32  data byte address.
REQ-011 dm_wdata  input  32  store data.
REQ-012 dm_ready  output  1  one-cycle pulse: data access complete, dm_rdata valid on load.
REQ-013 dm_rdata  output  32  load word, registered.
REQ-014 addr_err  output  1  pulses with if_ready/dm_ready when the request was misaligned.
REQ-015 mem_valid  output  1  memory request, held until mem_ack.
REQ-016 mem_we  output  1  memory write enable.
REQ-017 mem_addr  output  32  memory byte address.
REQ-018 mem_wdata  output  32  memory write data.
REQ-019 mem_rdata  input  32  memory read data, valid with mem_ack.
REQ-020 mem_ack  input  1  one-cycle memory completion; ignored unless mem_valid.

Function
REQ-021 FSM states IDLE, GRANT_IF, GRANT_DM, RESP; one access outstanding at a time.
REQ-022 IDLE: no request -> stay IDLE; any request -> arbitrate, register grant and payload, go GRANT_IF/GRANT_DM.
REQ-023 Priority: dm_req beats if_req, unless streak == STARVE_MAX and if_req = 1 -> IF wins.
REQ-024 streak: +1 on DM grant with if_req = 1 (saturates at STARVE_MAX); cleared on IF grant or DM grant with if_req = 0.
REQ-025 GRANT_x: mem_valid = 1, mem_addr/mem_we/mem_wdata from registered payload (IF: mem_we = 0, mem_wdata = 0); payload stable until mem_ack.
REQ-026 GRANT_x on mem_ack: capture mem_rdata into the owner's rdata register (stores leave dm_rdata unchanged); go RESP.
REQ-027 RESP: exactly one of if_ready/dm_ready = 1 for the owner; mem_valid = 0; next state IDLE.
REQ-028 Minimum latency: request seen in IDLE at cycle N, mem_ack at N+1 -> ready at N+2; no back-to-back grants (IDLE cycle between accesses).
REQ-029 Misaligned address (addr[1:0] != 0): no memory access; IDLE -> RESP directly; ready and addr_err pulse; rdata register written to 0; streak updated as a normal grant.
REQ-030 Requests and payload changes outside IDLE are ignored; a request deasserted before ready is undefined usage, no protection.
REQ-031 mem_ack in IDLE or RESP is ignored, no state change.

Reset
REQ-032 rst_n low: state IDLE, streak 0, all outputs 0 (including if_rdata, dm_rdata, mem_addr, mem_wdata), immediately and without clk.
REQ-033 Reset mid-access abandons it: no ready pulse; a late mem_ack after release is ignored.
REQ-034 First arbitration occurs at the first rising edge with rst_n high.

Verification
REQ-035 Fetch only: if_addr = 0x100, mem_ack one cycle after mem_valid with mem_rdata = 0x20080005 -> mem_addr = 0x100, mem_we = 0, if_ready pulse two cycles after request, if_rdata = 0x20080005.
REQ-036 Simultaneous: if_req and dm_req (load 0x200) in same IDLE cycle -> DM granted first, dm_ready, then IDLE, then IF granted.
REQ-037 Starvation, STARVE_MAX = 4: if_req held, dm_req re-asserted after every ready -> exactly 4 DM grants, 5th grant IF, then streak 0 and DM wins again.
REQ-038 Store: dm_we = 1, dm_addr = 0x40, dm_wdata = 0xDEADBEEF, 3-cycle mem_ack delay -> mem_we = 1, payload stable for all 3 cycles, dm_ready one cycle after ack, dm_rdata unchanged.
REQ-039 Misaligned: dm_addr = 0x42 -> mem_valid never asserted, dm_ready and addr_err pulse one cycle after request, dm_rdata = 0.
REQ-040 Reset in GRANT_DM before mem_ack -> outputs 0 asynchronously; mem_ack after release ignored; no dm_ready.
